// File: rtl/serial_arith_unit.sv
// Digit-serial adder/subtractor: D = A + Y(SEL,B) + CIN, DIGIT bits per clock, LSB first.
// Define SERIAL_ARITH_OVERFLOW_EN to build the signed-overflow flag V; otherwise V is tied low.
//
// state | meaning
// IDLE  | ready for operands, in_ready=1
// RUN   | one digit per cycle, carry kept in carry_q
// HOLD  | result presented with out_valid=1 until out_ready
module serial_arith_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       SEL,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             COUT,
    output logic             V
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]             state_q, state_d;
    logic                   arm_q;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       d_q, d_d;
    logic [1:0]             sel_q, sel_d;
    logic                   carry_q, carry_d;
    logic                   cout_q, cout_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DIGIT-1:0]       y_dig;
    logic [DIGIT:0]         sum;
    logic [WIDTH+DIGIT-1:0] d_cat;
    logic                   accept;
    logic                   last;

    // Y is formed per digit from the captured B, so SEL only needs two bits of storage.
    always_comb begin
        y_dig = '0;
        case (sel_q)
            2'b00:   y_dig = b_q[DIGIT-1:0];
            2'b01:   y_dig = ~b_q[DIGIT-1:0];
            2'b10:   y_dig = '0;
            default: y_dig = '1;
        endcase
    end

    assign sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, y_dig} + {{DIGIT{1'b0}}, carry_q};
    assign d_cat  = {sum[DIGIT-1:0], d_q};
    assign last   = (cnt_q == '0);
    // arm_q blocks a capture on the first edge after reset is released.
    assign accept = (state_q == S_IDLE) && in_valid && arm_q;

`ifdef SERIAL_ARITH_OVERFLOW_EN
    logic v_q, v_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ARITH_OVERFLOW_EN
        v_d     = v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    sel_d   = SEL;
                    carry_d = CIN;
                    cnt_d   = CW'(STEPS - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                d_d     = d_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = sum[DIGIT];
                if (last) begin
                    cout_d  = sum[DIGIT];
`ifdef SERIAL_ARITH_OVERFLOW_EN
                    // carry into the MSB is recovered as a ^ y ^ sum at that bit
                    v_d     = sum[DIGIT] ^ sum[DIGIT-1] ^ a_q[DIGIT-1] ^ y_dig[DIGIT-1];
`endif
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            sel_q   <= 2'b00;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ARITH_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    assign V = v_q;
`else
    assign V = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign D         = d_q;
    assign COUT      = cout_q;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Bench for serial_arith_unit: an 8-bit/1-digit and a 16-bit/4-digit instance against an arithmetic model.
module tb_serial_arith_unit;

`ifdef SERIAL_ARITH_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        iv8 = 1'b0, ir8, cin8 = 1'b0, ov8, or8 = 1'b0, cout8, v8;
    logic [1:0]  sel8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0, d8;

    logic        iv16 = 1'b0, ir16, cin16 = 1'b0, ov16, or16 = 1'b0, cout16, v16;
    logic [1:0]  sel16 = 2'b00;
    logic [15:0] a16 = '0, b16 = '0, d16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_arith_unit #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .SEL(sel8),
        .A(a8), .B(b8), .CIN(cin8), .out_valid(ov8), .out_ready(or8),
        .D(d8), .COUT(cout8), .V(v8)
    );

    serial_arith_unit #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .SEL(sel16),
        .A(a16), .B(b16), .CIN(cin16), .out_valid(ov16), .out_ready(or16),
        .D(d16), .COUT(cout16), .V(v16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {V, COUT, D} straight from the arithmetic definition
    function automatic logic [17:0] model(input bit big, input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] sel, input logic cin);
        int w    = big ? 16 : 8;
        int mask = (1 << w) - 1;
        int ai   = int'(a) & mask;
        int yi;
        int s, d, co, am, ym, dm;
        bit v;
        case (sel)
            2'd0:    yi = int'(b);
            2'd1:    yi = ~int'(b);
            2'd2:    yi = 0;
            default: yi = -1;
        endcase
        yi = yi & mask;
        s  = ai + yi + (cin ? 1 : 0);
        d  = s & mask;
        co = (s >> w) & 1;
        am = (ai >> (w - 1)) & 1;
        ym = (yi >> (w - 1)) & 1;
        dm = (d >> (w - 1)) & 1;
        v  = (am == ym) && (dm != am);
        return {v, co[0], d[15:0]};
    endfunction

    function automatic logic get_ov(input bit big);
        return big ? ov16 : ov8;
    endfunction
    function automatic logic get_ir(input bit big);
        return big ? ir16 : ir8;
    endfunction
    function automatic logic [15:0] get_d(input bit big);
        return big ? d16 : {8'h00, d8};
    endfunction
    function automatic logic get_cout(input bit big);
        return big ? cout16 : cout8;
    endfunction
    function automatic logic get_v(input bit big);
        return big ? v16 : v8;
    endfunction

    task automatic set_in(input bit big, input logic iv, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] sel, input logic cin);
        if (big) begin
            iv16 = iv; a16 = a; b16 = b; sel16 = sel; cin16 = cin;
        end else begin
            iv8 = iv; a8 = a[7:0]; b8 = b[7:0]; sel8 = sel; cin8 = cin;
        end
    endtask

    task automatic set_ready(input bit big, input logic r);
        if (big) or16 = r;
        else     or8  = r;
    endtask

    // Called #1 after a clock edge with the unit idle.
    task automatic run_op(input bit big, input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                          input logic cin, input int hold, input bit early, input string tag);
        logic [17:0] m = model(big, a, b, sel, cin);
        int steps = big ? 4 : 8;
        int lat;
        check({tag, "_ready_idle"}, 32'(get_ir(big)), 32'd1);
        set_in(big, 1'b1, a, b, sel, cin);
        set_ready(big, early);
        @(posedge clk); #1;
        lat = 1;
        check({tag, "_busy"}, 32'(get_ir(big)), 32'd0);
        // late operand changes and stray in_valid must not disturb the running op
        set_in(big, !early, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
        while (!get_ov(big) && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(steps + 1));
        check({tag, "_D"}, 32'(get_d(big)), 32'(m[15:0]));
        check({tag, "_COUT"}, 32'(get_cout(big)), 32'(m[16]));
        check({tag, "_V"}, 32'(get_v(big)), 32'(m[17] & OVF));
        if (early) begin
            set_in(big, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
            @(posedge clk); #1;
            check({tag, "_one_hold"}, 32'(get_ov(big)), 32'd0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 32'(get_ov(big)), 32'd1);
                check({tag, "_hold_D"}, 32'(get_d(big)), 32'(m[15:0]));
                check({tag, "_hold_busy"}, 32'(get_ir(big)), 32'd0);
            end
            set_in(big, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
            set_ready(big, 1'b1);
            @(posedge clk); #1;
            check({tag, "_released"}, 32'(get_ov(big)), 32'd0);
        end
        check({tag, "_back_idle"}, 32'(get_ir(big)), 32'd1);
        set_ready(big, 1'b0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ir8), 32'd1);
        check("rst_valid", 32'(ov8), 32'd0);
        check("rst_D", 32'(d8), 32'd0);
        check("rst_COUT", 32'(cout8), 32'd0);
        check("rst_V", 32'(v8), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_op(1'b0, 16'h04, 16'h02, 2'b00, 1'b0, 0, 1'b0, "add");
        run_op(1'b0, 16'h04, 16'h02, 2'b01, 1'b1, 1, 1'b0, "sub");
        run_op(1'b0, 16'h00, 16'h5A, 2'b11, 1'b0, 0, 1'b1, "ones");
        run_op(1'b0, 16'h7F, 16'h01, 2'b00, 1'b0, 0, 1'b0, "ovf");
        run_op(1'b0, 16'h3C, 16'h0A, 2'b10, 1'b1, 5, 1'b0, "stall");
        run_op(1'b1, 16'h1234, 16'h0FFF, 2'b00, 1'b1, 0, 1'b0, "w16");

        // reset in the middle of RUN
        set_in(1'b0, 1'b1, 16'h55, 16'h11, 2'b00, 1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ir8), 32'd1);
        check("mid_rst_valid", 32'(ov8), 32'd0);
        check("mid_rst_D", 32'(d8), 32'd0);
        check("mid_rst_COUT", 32'(cout8), 32'd0);
        check("mid_rst_V", 32'(v8), 32'd0);
        #1 rst = 1'b0;
        set_in(1'b0, 1'b1, 16'h01, 16'h01, 2'b00, 1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0);
        check("first_edge_ignored", 32'(ir8), 32'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov8) seen = 1;
        end
        check("no_valid_after_rst", 32'(seen), 32'd0);
        run_op(1'b0, 16'hFF, 16'h01, 2'b00, 1'b0, 0, 1'b0, "post_rst");

        for (int i = 0; i < 20; i++) begin
            run_op(i[0], 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
